// File: rtl/bit_serial_alu_seq.sv
// Bit-serial sequencer around a 1-bit ALU slice: streams latched operands
// LSB-first through the slice and reassembles the result word.
module bit_serial_alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [1:0]       op_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_ainv,
   output logic             slice_binv,
   output logic [1:0]       slice_op,
   output logic             slice_carryin,
   input  logic             slice_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SUB = 2'b11;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] res_shift;
   logic             carry_nxt;
   logic             b_eff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Slice controls are only driven while bits are streaming.
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      slice_a       = 1'b0;
      slice_b       = 1'b0;
      slice_ainv    = 1'b0;
      slice_binv    = 1'b0;
      slice_op      = 2'b00;
      slice_carryin = 1'b0;
      case (state_q)
         S_RUN: begin
            busy          = 1'b1;
            slice_a       = a_q[0];
            slice_b       = b_q[0];
            slice_binv    = (op_q == OP_SUB);
            slice_op      = op_q[1] ? 2'b10 : op_q;
            slice_carryin = carry_q;
         end
         S_FIN:   done = 1'b1;
         default: ;
      endcase
   end

   assign b_eff     = slice_b ^ slice_binv;
   assign carry_nxt = op_q[1] & ((slice_a & b_eff) | (slice_a & carry_q) | (b_eff & carry_q));
   assign res_shift = {slice_result, res_q[WIDTH-1:1]};

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      y_d     = y_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               op_d    = op_in;
               res_d   = '0;
               cnt_d   = '0;
               carry_d = (op_in == OP_SUB);
            end
         end
         S_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_shift;
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            // Publish the finished word on the same edge that enters FIN.
            if (cnt_q == CNT_LAST) begin
               y_d    = res_shift;
               cout_d = carry_nxt;
               zero_d = (res_shift == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= 2'b00;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         y_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         y_q     <= y_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end

   assign y    = y_q;
   assign cout = cout_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq with a behavioural 1-bit ALU slice.
module tb_bit_serial_alu_seq;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a_in, b_in;
   logic [1:0]       op_in;
   logic             busy, done, cout, zero;
   logic [WIDTH-1:0] y;
   logic             slice_a, slice_b, slice_ainv, slice_binv, slice_carryin;
   logic [1:0]       slice_op;
   logic             slice_result;

   int passed = 0;
   int total  = 0;

   bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_in(a_in), .b_in(b_in), .op_in(op_in),
      .busy(busy), .done(done), .y(y), .cout(cout), .zero(zero),
      .slice_a(slice_a), .slice_b(slice_b), .slice_ainv(slice_ainv),
      .slice_binv(slice_binv), .slice_op(slice_op),
      .slice_carryin(slice_carryin), .slice_result(slice_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-bit ALU slice
   logic sa_eff, sb_eff;
   always_comb begin
      sa_eff = slice_a ^ slice_ainv;
      sb_eff = slice_b ^ slice_binv;
      case (slice_op)
         2'b00:   slice_result = sa_eff & sb_eff;
         2'b01:   slice_result = sa_eff | sb_eff;
         2'b10:   slice_result = sa_eff ^ sb_eff ^ slice_carryin;
         default: slice_result = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input bit hold);
      a_in  = a;
      b_in  = b;
      op_in = op;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_edges, input logic [1:0] eop,
                            input logic ebinv, input logic [7:0] ey, input logic ecout,
                            input logic ezero);
      int   n  = 0;
      int   bc = 0;
      bit   ctl_ok = 1'b1;
      logic first_cin;
      logic [7:0] y_done;
      first_cin = slice_carryin;
      while (done !== 1'b1 && n < 20) begin
         if (busy === 1'b1) bc++;
         if (slice_op !== eop || slice_binv !== ebinv || slice_ainv !== 1'b0) ctl_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, n, exp_edges);
      check({tag, " busy_cycles"}, bc, exp_edges);
      check({tag, " slice_ctl"}, ctl_ok, 1);
      check({tag, " first_cin"}, first_cin, ebinv);
      check({tag, " y"}, y, ey);
      check({tag, " cout"}, cout, ecout);
      check({tag, " zero"}, zero, ezero);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " slice_op_fin"}, slice_op, 0);
      y_done = y;
      @(posedge clk); #1;
      check({tag, " done_pulse"}, done, 0);
      check({tag, " y_hold"}, y, y_done);
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      op_in = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst y", y, 0);
      check("rst cout_zero", {cout, zero}, 0);
      check("rst slice", {slice_a, slice_b, slice_ainv, slice_binv, slice_op, slice_carryin}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(8'h3C, 8'h55, 2'b10, 1'b0);
      wait_done("add_3c_55", 8, 2'b10, 1'b0, 8'h91, 1'b0, 1'b0);
      issue(8'hFF, 8'h01, 2'b10, 1'b0);
      wait_done("add_ff_01", 8, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1);
      issue(8'h10, 8'h01, 2'b11, 1'b0);
      wait_done("sub_10_01", 8, 2'b10, 1'b1, 8'h0F, 1'b1, 1'b0);
      issue(8'h01, 8'h02, 2'b11, 1'b0);
      wait_done("sub_01_02", 8, 2'b10, 1'b1, 8'hFF, 1'b0, 1'b0);
      issue(8'hA5, 8'h0F, 2'b00, 1'b0);
      wait_done("and_a5_0f", 8, 2'b00, 1'b0, 8'h05, 1'b0, 1'b0);
      issue(8'hA0, 8'h05, 2'b01, 1'b0);
      wait_done("or_a0_05", 8, 2'b01, 1'b0, 8'hA5, 1'b0, 1'b0);

      // start held high through done: second op captured in the IDLE cycle after done
      issue(8'h3C, 8'h55, 2'b10, 1'b1);
      wait_done("held_first", 8, 2'b10, 1'b0, 8'h91, 1'b0, 1'b0);
      check("held idle_busy", busy, 0);
      a_in  = 8'h05;
      b_in  = 8'h05;
      op_in = 2'b11;
      @(posedge clk); #1;
      start = 1'b0;
      check("held accepted", busy, 1);
      wait_done("held_second", 8, 2'b10, 1'b1, 8'h00, 1'b1, 1'b1);

      // start pulse mid-RUN with new operands is ignored
      issue(8'h12, 8'h34, 2'b10, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      op_in = 2'b11;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("glitch", 5, 2'b10, 1'b0, 8'h46, 1'b0, 1'b0);
      check("glitch no_restart", busy, 0);

      // reset in the 4th RUN cycle aborts the operation
      issue(8'hFF, 8'hFF, 2'b10, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst busy", busy, 0);
      check("mid_rst y", y, 0);
      check("mid_rst slice", {slice_a, slice_b, slice_binv, slice_op, slice_carryin}, 0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) done_seen++;
         if (i == 2) rst_n = 1'b1;
      end
      check("mid_rst no_done", done_seen, 0);
      issue(8'h01, 8'h01, 2'b10, 1'b0);
      wait_done("post_rst_add", 8, 2'b10, 1'b0, 8'h02, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
